// File: rtl/serv_ibus_prefetch_pkg.sv
// Shared constants and address helpers for the SERV instruction-bus prefetcher.
`timescale 1ns/1ps
package serv_ibus_prefetch_pkg;

   localparam int ADR_W   = 32;
   localparam int DAT_W   = 32;
   localparam int STATE_W = 3;

   // Clear the byte-offset bits; the instruction bus only ever carries word addresses.
   function automatic logic [ADR_W-1:0] word_align(input logic [ADR_W-1:0] adr);
      return adr & 32'hFFFF_FFFC;
   endfunction

   // Address of the following word; wraps modulo 2^32 at the top of memory.
   function automatic logic [ADR_W-1:0] next_word_adr(input logic [ADR_W-1:0] adr);
      return (adr & 32'hFFFF_FFFC) + 32'd4;
   endfunction

endpackage

// File: rtl/serv_ibus_prefetch.sv
// Instruction fetch sequencer between the SERV core ibus master and the external
// Wishbone ibus, with an optional one-entry sequential prefetch buffer.
//
// Handshakes: the core raises i_cpu_cyc with a stable i_cpu_adr and holds both until
// it sees the single-cycle o_cpu_ack; o_cpu_rdt is meaningful only in that cycle and
// i_cpu_cyc is not looked at during it. On the Wishbone side o_wb_cyc (stb==cyc) is
// held with a stable o_wb_adr until a single-cycle i_wb_ack; i_wb_ack is only honoured
// while o_wb_cyc is high, so a late ack after reset or outside a cycle is ignored.
`timescale 1ns/1ps
module serv_ibus_prefetch
   import serv_ibus_prefetch_pkg::*;
#(
   parameter int WITH_PREFETCH = 1
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic [ADR_W-1:0]   i_cpu_adr,
   input  logic               i_cpu_cyc,
   output logic [DAT_W-1:0]   o_cpu_rdt,
   output logic               o_cpu_ack,
   input  logic               i_flush,
   output logic [ADR_W-1:0]   o_wb_adr,
   output logic               o_wb_cyc,
   input  logic [DAT_W-1:0]   i_wb_rdt,
   input  logic               i_wb_ack,
   output logic               o_hit,
   output logic [STATE_W-1:0] o_dbg_state
);

   localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] S_HIT      = 3'd1;
   localparam logic [STATE_W-1:0] S_DEMAND   = 3'd2;
   localparam logic [STATE_W-1:0] S_PF_ISSUE = 3'd3;
   localparam logic [STATE_W-1:0] S_PREFETCH = 3'd4;

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nxt;

   // Prefetch buffer: one {valid, adr, data} entry.
   logic               r_buf_valid;
   logic [ADR_W-1:0]   r_buf_adr;
   logic [DAT_W-1:0]   r_buf_data;

   // Registered outputs.
   logic [ADR_W-1:0]   r_wb_adr;
   logic               r_wb_cyc;
   logic               r_cpu_ack;
   logic [DAT_W-1:0]   r_cpu_rdt;
   logic               r_hit;

   // Address of the instruction most recently delivered (or being demanded).
   logic [ADR_W-1:0]   r_last_adr;
   // Set when a flush lands while a speculative fetch is pending; its data is then dropped.
   logic               r_pf_drop;

   logic [ADR_W-1:0]   w_wb_adr_nxt;
   logic               w_wb_cyc_nxt;
   logic               w_cpu_ack_nxt;
   logic [DAT_W-1:0]   w_cpu_rdt_nxt;
   logic               w_hit_nxt;
   logic               w_buf_valid_nxt;
   logic [ADR_W-1:0]   w_buf_adr_nxt;
   logic [DAT_W-1:0]   w_buf_data_nxt;
   logic [ADR_W-1:0]   w_last_adr_nxt;
   logic               w_pf_drop_nxt;

   logic               w_buf_hit;
   logic               w_bus_done;
   logic               w_req_match;
   logic               w_req_other;

   // A flush in the same cycle as a would-be hit forces the request out to the bus.
   assign w_buf_hit   = i_cpu_cyc & r_buf_valid & (i_cpu_adr == r_buf_adr) & ~i_flush;
   assign w_bus_done  = r_wb_cyc & i_wb_ack;
   assign w_req_match = i_cpu_cyc & (i_cpu_adr == r_wb_adr);
   assign w_req_other = i_cpu_cyc & (i_cpu_adr != r_wb_adr);

   // State register.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_buf_hit) begin
               w_state_nxt = S_HIT;
            end else if (i_cpu_cyc) begin
               w_state_nxt = S_DEMAND;
            end
         end
         S_HIT: begin
            w_state_nxt = S_PF_ISSUE;
         end
         S_DEMAND: begin
            if (w_bus_done) begin
               w_state_nxt = S_PF_ISSUE;
            end
         end
         S_PF_ISSUE: begin
            w_state_nxt = (WITH_PREFETCH != 0) ? S_PREFETCH : S_IDLE;
         end
         S_PREFETCH: begin
            // The speculative cycle always runs to its ack; only then is the core's
            // request (if any) resolved as a merge or a redirect.
            if (w_bus_done) begin
               if (w_req_match) begin
                  w_state_nxt = S_PF_ISSUE;
               end else if (w_req_other) begin
                  w_state_nxt = S_DEMAND;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Next values for the outputs, the buffer and the bookkeeping registers.
   always_comb begin
      w_wb_adr_nxt    = r_wb_adr;
      w_wb_cyc_nxt    = r_wb_cyc;
      w_cpu_ack_nxt   = 1'b0;
      w_cpu_rdt_nxt   = r_cpu_rdt;
      w_hit_nxt       = 1'b0;
      w_buf_valid_nxt = r_buf_valid;
      w_buf_adr_nxt   = r_buf_adr;
      w_buf_data_nxt  = r_buf_data;
      w_last_adr_nxt  = r_last_adr;
      w_pf_drop_nxt   = r_pf_drop;

      case (r_state)
         S_IDLE: begin
            if (w_buf_hit) begin
               w_cpu_ack_nxt   = 1'b1;
               w_hit_nxt       = 1'b1;
               w_cpu_rdt_nxt   = r_buf_data;
               w_buf_valid_nxt = 1'b0;
               w_last_adr_nxt  = word_align(i_cpu_adr);
            end else if (i_cpu_cyc) begin
               w_wb_adr_nxt   = word_align(i_cpu_adr);
               w_wb_cyc_nxt   = 1'b1;
               w_last_adr_nxt = word_align(i_cpu_adr);
            end
         end
         S_DEMAND: begin
            if (!r_wb_cyc) begin
               // Entered from a redirected prefetch: the bus was idle for one cycle so
               // the address never changes under a live cycle; start the demand now.
               w_wb_adr_nxt = r_last_adr;
               w_wb_cyc_nxt = 1'b1;
            end else if (i_wb_ack) begin
               w_wb_cyc_nxt  = 1'b0;
               w_cpu_ack_nxt = 1'b1;
               w_cpu_rdt_nxt = i_wb_rdt;
            end
         end
         S_PF_ISSUE: begin
            if (WITH_PREFETCH != 0) begin
               // The buffer is about to be replaced by the next sequential word.
               w_wb_adr_nxt    = next_word_adr(r_last_adr);
               w_wb_cyc_nxt    = 1'b1;
               w_buf_valid_nxt = 1'b0;
               w_pf_drop_nxt   = 1'b0;
            end
         end
         S_PREFETCH: begin
            if (w_bus_done) begin
               w_wb_cyc_nxt = 1'b0;
               if (w_req_match) begin
                  // Core asked for the word in flight: hand it over directly. The data
                  // is fresh from the bus, so an earlier flush does not matter here.
                  w_cpu_ack_nxt  = 1'b1;
                  w_cpu_rdt_nxt  = i_wb_rdt;
                  w_last_adr_nxt = r_wb_adr;
               end else if (w_req_other) begin
                  w_last_adr_nxt = word_align(i_cpu_adr);
               end else if (!r_pf_drop && !i_flush) begin
                  w_buf_valid_nxt = 1'b1;
                  w_buf_adr_nxt   = r_wb_adr;
                  w_buf_data_nxt  = i_wb_rdt;
               end
            end
         end
         default: begin
         end
      endcase

      if (i_flush) begin
         w_buf_valid_nxt = 1'b0;
         if ((r_state == S_PF_ISSUE) || (r_state == S_PREFETCH)) begin
            w_pf_drop_nxt = 1'b1;
         end
      end
   end

   // Register the outputs and the buffer.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_wb_adr    <= '0;
         r_wb_cyc    <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_cpu_rdt   <= '0;
         r_hit       <= 1'b0;
         r_buf_valid <= 1'b0;
         r_buf_adr   <= '0;
         r_buf_data  <= '0;
         r_last_adr  <= '0;
         r_pf_drop   <= 1'b0;
      end else begin
         r_wb_adr    <= w_wb_adr_nxt;
         r_wb_cyc    <= w_wb_cyc_nxt;
         r_cpu_ack   <= w_cpu_ack_nxt;
         r_cpu_rdt   <= w_cpu_rdt_nxt;
         r_hit       <= w_hit_nxt;
         r_buf_valid <= w_buf_valid_nxt;
         r_buf_adr   <= w_buf_adr_nxt;
         r_buf_data  <= w_buf_data_nxt;
         r_last_adr  <= w_last_adr_nxt;
         r_pf_drop   <= w_pf_drop_nxt;
      end
   end

   assign o_wb_adr    = r_wb_adr;
   assign o_wb_cyc    = r_wb_cyc;
   assign o_cpu_ack   = r_cpu_ack;
   assign o_cpu_rdt   = r_cpu_rdt;
   assign o_hit       = r_hit;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// Bench for serv_ibus_prefetch: one prefetching and one pass-through instance share a
// Wishbone memory model (ack 3 cycles after the first sampled cycle, data = C0DE0000|adr).
`timescale 1ns/1ps
module tb_serv_ibus_prefetch;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_cyc = 1'b0;
   logic [31:0] cpu_adr = 32'd0;
   logic        flush = 1'b0;
   logic        stray_ack = 1'b0;
   logic        sel_np = 1'b0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdt = 32'd0;

   logic [31:0] d_cpu_rdt, d_wb_adr, n_cpu_rdt, n_wb_adr;
   logic        d_cpu_ack, d_wb_cyc, d_hit, n_cpu_ack, n_wb_cyc, n_hit;
   logic [2:0]  d_dbg, n_dbg;
   logic        d_cyc_in, n_cyc_in, d_wb_ack, n_wb_ack;
   logic        m_cpu_ack, m_hit, m_wb_cyc;
   logic [31:0] m_cpu_rdt, m_wb_adr;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc_cnt = 0;
   int          mem_ack_cyc = 0;
   int          last_ack_cyc = 0;
   int          ack_total = 0;
   logic [32:0] exp_q[$];
   logic [31:0] wb_log[$];

   assign d_cyc_in  = cpu_cyc & ~sel_np;
   assign n_cyc_in  = cpu_cyc & sel_np;
   assign d_wb_ack  = (mem_ack & ~sel_np) | stray_ack;
   assign n_wb_ack  = mem_ack & sel_np;
   assign m_cpu_ack = sel_np ? n_cpu_ack : d_cpu_ack;
   assign m_cpu_rdt = sel_np ? n_cpu_rdt : d_cpu_rdt;
   assign m_hit     = sel_np ? n_hit : d_hit;
   assign m_wb_cyc  = sel_np ? n_wb_cyc : d_wb_cyc;
   assign m_wb_adr  = sel_np ? n_wb_adr : d_wb_adr;

   serv_ibus_prefetch #(.WITH_PREFETCH(1)) dut (
      .clk(clk), .i_rst(rst), .i_cpu_adr(cpu_adr), .i_cpu_cyc(d_cyc_in),
      .o_cpu_rdt(d_cpu_rdt), .o_cpu_ack(d_cpu_ack), .i_flush(flush),
      .o_wb_adr(d_wb_adr), .o_wb_cyc(d_wb_cyc), .i_wb_rdt(mem_rdt), .i_wb_ack(d_wb_ack),
      .o_hit(d_hit), .o_dbg_state(d_dbg)
   );

   serv_ibus_prefetch #(.WITH_PREFETCH(0)) dut_np (
      .clk(clk), .i_rst(rst), .i_cpu_adr(cpu_adr), .i_cpu_cyc(n_cyc_in),
      .o_cpu_rdt(n_cpu_rdt), .o_cpu_ack(n_cpu_ack), .i_flush(flush),
      .o_wb_adr(n_wb_adr), .o_wb_cyc(n_wb_cyc), .i_wb_rdt(mem_rdt), .i_wb_ack(n_wb_ack),
      .o_hit(n_hit), .o_dbg_state(n_dbg)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic flush_pulse();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   // Issue one core fetch, push its expected {hit, rdt}, hold cyc until ack (bounded).
   task automatic fetch(input logic [31:0] adr, input logic [31:0] exp_rdt, input logic exp_hit,
                        input int exp_lat, input logic with_flush);
      int  start;
      bit  done;
      @(negedge clk);
      cpu_adr = adr;
      cpu_cyc = 1'b1;
      flush   = with_flush;
      exp_q.push_back({exp_hit, exp_rdt});
      start = cyc_cnt;
      done  = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         flush = 1'b0;
         if (m_cpu_ack) done = 1'b1;
      end
      cpu_cyc = 1'b0;
      last_ack_cyc = cyc_cnt;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL fetch_timeout adr=%h actual=no_ack expected=ack_within_40", adr);
         void'(exp_q.pop_back());
      end else if (exp_lat >= 0) begin
         check("fetch_latency", 32'(last_ack_cyc - start), 32'(exp_lat));
      end
   endtask

   // Wishbone memory model for whichever instance is selected.
   initial begin
      int cnt;
      logic [31:0] cur;
      cnt = 0;
      cur = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_ack = 1'b0;
            cnt = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
         end else if (m_wb_cyc) begin
            if (cnt == 0) begin
               cur = m_wb_adr;
               wb_log.push_back(cur);
               check("wb_adr_align", {30'd0, cur[1:0]}, 32'd0);
            end else begin
               check("wb_adr_stable", m_wb_adr, cur);
            end
            if (cnt == LAT) begin
               mem_ack = 1'b1;
               mem_rdt = 32'hC0DE_0000 | cur;
               mem_ack_cyc = cyc_cnt;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Scoreboard monitor: every core ack pops one expectation.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (!rst && m_cpu_ack) begin
            ack_total++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ack actual=ack rdt=%h expected=no_ack", m_cpu_rdt);
            end else begin
               e = exp_q.pop_front();
               check("cpu_rdt", m_cpu_rdt, e[31:0]);
               check("cpu_hit", {31'd0, m_hit}, {31'd0, e[32]});
            end
         end
         if (!rst && m_hit && !m_cpu_ack) begin
            n_checks++;
            n_fail++;
            $display("FAIL hit_without_ack actual=1 expected=0");
         end
      end
   end

   // Directed stimulus.
   initial begin
      int n0;
      int ack_before;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_cpu_ack", {31'd0, d_cpu_ack}, 32'd0);
      check("rst_wb_cyc", {31'd0, d_wb_cyc}, 32'd0);
      check("rst_hit", {31'd0, d_hit}, 32'd0);
      check("rst_cpu_rdt", d_cpu_rdt, 32'd0);
      check("rst_wb_adr", d_wb_adr, 32'd0);
      check("rst_state", {29'd0, d_dbg}, 32'd0);
      check("rst_np_wb_cyc", {31'd0, n_wb_cyc}, 32'd0);
      rst = 1'b0;
      idle(2);

      // 1. Sequential run 0x0, 0x4, 0x8.
      n0 = wb_log.size();
      fetch(32'h0, 32'hC0DE_0000, 1'b0, 5, 1'b0);
      idle(8);
      fetch(32'h4, 32'hC0DE_0004, 1'b1, 1, 1'b0);
      idle(8);
      fetch(32'h8, 32'hC0DE_0008, 1'b1, 1, 1'b0);
      idle(8);
      check("seq_wb_count", 32'(wb_log.size() - n0), 32'd4);
      check("seq_pf_adr", wb_log[n0 + 3], 32'hC);

      // 2. Branch miss: buffer at 0x104, core jumps to 0x200.
      fetch(32'h100, 32'hC0DE_0100, 1'b0, 5, 1'b0);
      idle(8);
      n0 = wb_log.size();
      fetch(32'h200, 32'hC0DE_0200, 1'b0, 5, 1'b0);
      idle(8);
      check("miss_wb_count", 32'(wb_log.size() - n0), 32'd2);
      check("miss_demand_adr", wb_log[n0], 32'h200);
      check("miss_pf_adr", wb_log[n0 + 1], 32'h204);

      // 3. Merge: request 0x8 while its prefetch is in flight.
      fetch(32'h4, 32'hC0DE_0004, 1'b0, 5, 1'b0);
      n0 = wb_log.size();
      fetch(32'h8, 32'hC0DE_0008, 1'b0, 4, 1'b0);
      check("merge_wb_count", 32'(wb_log.size() - n0), 32'd1);
      check("merge_wb_adr", wb_log[n0], 32'h8);
      check("merge_ack_after_wb_ack", 32'(last_ack_cyc - mem_ack_cyc), 32'd1);
      idle(8);

      // 4. Mismatch: request 0x300 while 0x8 prefetch is in flight.
      fetch(32'h4, 32'hC0DE_0004, 1'b0, 5, 1'b0);
      n0 = wb_log.size();
      fetch(32'h300, 32'hC0DE_0300, 1'b0, -1, 1'b0);
      check("redir_wb_count", 32'(wb_log.size() - n0), 32'd2);
      check("redir_first_adr", wb_log[n0], 32'h8);
      check("redir_second_adr", wb_log[n0 + 1], 32'h300);
      idle(8);

      // 5. Flush with buffer valid at 0x10.
      fetch(32'hC, 32'hC0DE_000C, 1'b0, 5, 1'b0);
      idle(8);
      flush_pulse();
      n0 = wb_log.size();
      fetch(32'h10, 32'hC0DE_0010, 1'b0, 5, 1'b0);
      check("flush_wb_adr", wb_log[n0], 32'h10);
      idle(8);
      // Flush in the same cycle as a would-be hit on 0x14.
      n0 = wb_log.size();
      fetch(32'h14, 32'hC0DE_0014, 1'b0, 5, 1'b1);
      check("flush_hit_wb_adr", wb_log[n0], 32'h14);
      // Flush while the 0x18 prefetch is in flight: its data must not be kept.
      flush_pulse();
      idle(8);
      n0 = wb_log.size();
      fetch(32'h18, 32'hC0DE_0018, 1'b0, 5, 1'b0);
      check("flush_pf_wb_adr", wb_log[n0], 32'h18);
      idle(8);

      // 6. Reset in the middle of a demand cycle, then a stray ack.
      @(negedge clk);
      cpu_adr = 32'h40;
      cpu_cyc = 1'b1;
      @(negedge clk);
      check("rst_mid_wb_cyc_before", {31'd0, d_wb_cyc}, 32'd1);
      check("rst_mid_wb_adr_before", d_wb_adr, 32'h40);
      rst = 1'b1;
      cpu_cyc = 1'b0;
      @(negedge clk);
      check("rst_mid_wb_cyc_after", {31'd0, d_wb_cyc}, 32'd0);
      check("rst_mid_cpu_ack", {31'd0, d_cpu_ack}, 32'd0);
      check("rst_mid_state", {29'd0, d_dbg}, 32'd0);
      rst = 1'b0;
      ack_before = ack_total;
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      idle(4);
      check("stray_ack_no_cpu_ack", 32'(ack_total - ack_before), 32'd0);
      check("stray_ack_no_wb_cyc", {31'd0, d_wb_cyc}, 32'd0);
      fetch(32'h40, 32'hC0DE_0040, 1'b0, 5, 1'b0);
      idle(8);

      // WITH_PREFETCH=0 rerun of the sequential run: no speculative cycles.
      sel_np = 1'b1;
      idle(2);
      n0 = wb_log.size();
      fetch(32'h0, 32'hC0DE_0000, 1'b0, 5, 1'b0);
      idle(8);
      fetch(32'h4, 32'hC0DE_0004, 1'b0, 5, 1'b0);
      idle(8);
      fetch(32'h8, 32'hC0DE_0008, 1'b0, 5, 1'b0);
      idle(8);
      check("np_wb_count", 32'(wb_log.size() - n0), 32'd3);
      check("np_wb_adr0", wb_log[n0], 32'h0);
      check("np_wb_adr1", wb_log[n0 + 1], 32'h4);
      check("np_wb_adr2", wb_log[n0 + 2], 32'h8);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
